// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master side requests an addition; the slave side returns the result.
interface bit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum_out, cout
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum_out, cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one gate-level full-adder cell, fed LSB first.
// Takes WIDTH cycles per addition, then pulses done for one cycle.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  bit_serial_adder_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             fa_a, fa_b, fa_c, fa_p, fa_sum, fa_carry;
  logic [WIDTH-1:0] s_next;

  // Full-adder cell
  assign fa_a     = a_sh_q[0];
  assign fa_b     = b_sh_q[0];
  assign fa_c     = carry_q;
  assign fa_p     = fa_a ^ fa_b;
  assign fa_sum   = fa_p ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_p & fa_c);

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_next = fa_sum;
    end else begin : g_wn
      assign s_next = {fa_sum, s_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          a_sh_d  = bus_io.a_in;
          b_sh_d  = bus_io.b_in;
          carry_d = bus_io.cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        carry_d = fa_carry;
        s_sh_d  = s_next;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          sum_d   = s_next;
          cout_d  = fa_carry;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_io.busy    = (state_q == StShift);
  assign bus_io.done    = (state_q == StDone);
  assign bus_io.sum_out = sum_q;
  assign bus_io.cout    = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder at WIDTH 8, 4 and 1.
// One shared clock/reset; sel picks which instance is observed.
module tb_bit_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8, start4, start1;
  logic [7:0] a, b;
  logic       cin;
  int         sel;

  logic       obs_busy, obs_done, obs_cout;
  logic [7:0] obs_sum;

  int checks;
  int failures;

  bit_serial_adder_if #(.WIDTH(8)) if8 ();
  bit_serial_adder_if #(.WIDTH(4)) if4 ();
  bit_serial_adder_if #(.WIDTH(1)) if1 ();

  assign if8.start = start8;
  assign if8.a_in  = a;
  assign if8.b_in  = b;
  assign if8.cin   = cin;
  assign if4.start = start4;
  assign if4.a_in  = a[3:0];
  assign if4.b_in  = b[3:0];
  assign if4.cin   = cin;
  assign if1.start = start1;
  assign if1.a_in  = a[0:0];
  assign if1.b_in  = b[0:0];
  assign if1.cin   = cin;

  bit_serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus_io(if8));
  bit_serial_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus_io(if4));
  bit_serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus_io(if1));

  always_comb begin
    obs_busy = 1'b0;
    obs_done = 1'b0;
    obs_sum  = 8'h00;
    obs_cout = 1'b0;
    case (sel)
      0: begin
        obs_busy = if8.busy;
        obs_done = if8.done;
        obs_sum  = if8.sum_out;
        obs_cout = if8.cout;
      end
      1: begin
        obs_busy = if4.busy;
        obs_done = if4.done;
        obs_sum  = {4'h0, if4.sum_out};
        obs_cout = if4.cout;
      end
      default: begin
        obs_busy = if1.busy;
        obs_done = if1.done;
        obs_sum  = {7'h00, if1.sum_out};
        obs_cout = if1.cout;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one addition on instance s, scramble operands after acceptance, then check result,
  // busy length and single-cycle done.
  task automatic run_op(input int s, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic [7:0] es, input logic ec,
                        input int w, input string tag);
    int n_busy;
    bit seen;
    sel    = s;
    a      = ta;
    b      = tb_v;
    cin    = tc;
    start8 = (s == 0);
    start4 = (s == 1);
    start1 = (s == 2);
    tick();
    start8 = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    a      = ~ta;
    b      = ~tb_v;
    cin    = ~tc;
    n_busy = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (obs_done) seen = 1'b1;
      else begin
        if (obs_busy) n_busy++;
        tick();
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(n_busy), 32'(w));
    chk({tag, "_sum"}, 32'(obs_sum), 32'(es));
    chk({tag, "_cout"}, 32'(obs_cout), 32'(ec));
    tick();
    chk({tag, "_done_pulse"}, 32'(obs_done), 32'd0);
  endtask

  initial begin
    int n_done;
    bit seen;
    logic [7:0] es;
    logic       ec;
    int         s4;
    checks   = 0;
    failures = 0;
    sel      = 0;
    rst      = 1'b1;
    start8   = 1'b0;
    start4   = 1'b0;
    start1   = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    cin      = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(obs_busy), 32'd0);
    chk("rst_done", 32'(obs_done), 32'd0);
    chk("rst_sum", 32'(obs_sum), 32'd0);
    chk("rst_cout", 32'(obs_cout), 32'd0);
    rst = 1'b0;
    tick();

    run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8, "w8_ff_01");
    run_op(0, 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 8, "w8_5a_a5_c");
    run_op(0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 8, "w8_0_0_c");
    run_op(0, 8'h3C, 8'h29, 1'b0, 8'h65, 1'b0, 8, "w8_3c_29");

    // Second start mid-SHIFT with new operands must be ignored
    sel    = 0;
    a      = 8'h12;
    b      = 8'h34;
    cin    = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    start8 = 1'b1;
    a      = 8'h11;
    b      = 8'h11;
    cin    = 1'b1;
    tick();
    start8 = 1'b0;
    chk("ign_busy", 32'(obs_busy), 32'd1);
    chk("ign_sum_held", 32'(obs_sum), 32'h65);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (obs_done) seen = 1'b1;
      else tick();
    end
    chk("ign_done_seen", 32'(seen), 32'd1);
    chk("ign_sum", 32'(obs_sum), 32'h46);
    chk("ign_cout", 32'(obs_cout), 32'd0);
    tick();
    tick();
    chk("ign_no_restart", 32'(obs_busy), 32'd0);

    // Reset mid-SHIFT aborts without a done pulse
    a      = 8'hFF;
    b      = 8'hFF;
    cin    = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(obs_busy), 32'd0);
    chk("abort_done", 32'(obs_done), 32'd0);
    chk("abort_sum", 32'(obs_sum), 32'd0);
    chk("abort_cout", 32'(obs_cout), 32'd0);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (obs_done) n_done++;
      tick();
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    run_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8, "w8_after_rst");

    // Reset and start together: reset wins
    rst    = 1'b1;
    start8 = 1'b1;
    tick();
    rst    = 1'b0;
    start8 = 1'b0;
    tick();
    chk("rst_start_busy", 32'(obs_busy), 32'd0);
    chk("rst_start_sum", 32'(obs_sum), 32'd0);

    // WIDTH=4 exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          s4 = ia + ib + ic;
          es = 8'(s4 % 16);
          ec = (s4 >= 16);
          run_op(1, 8'(ia), 8'(ib), ic[0], es, ec, 4, "w4_sweep");
        end
      end
    end

    // WIDTH=1
    run_op(2, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1, "w1_1_1_1");
    run_op(2, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1, "w1_0_1_0");
    run_op(2, 8'h01, 8'h00, 1'b1, 8'h00, 1'b1, 1, "w1_1_0_1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
